// File: rtl/aes_inv_sbox.sv
// AES inverse S-box (InvSubBytes) over one 32-bit word: four independent byte lanes.
// Latency 1 cycle (registered, default) or 0 cycles when AES_INV_SBOX_COMB_EN is defined.
// No backpressure: accepts one word per cycle whenever i_en is high, never stalls.
//
// Ports:
//   i_clk           rising-edge clock (unused in the combinational build)
//   i_rst           asynchronous active-high reset (unused in the combinational build)
//   i_en            input word valid / capture enable
//   i_inv_wrd_sbox  input word, byte lanes [31:24],[23:16],[15:8],[7:0]
//   o_inv_wrd_sbox  inverse-substituted word, same lane order
//   o_valid         o_inv_wrd_sbox holds a fresh result this cycle
//
// Build option: define AES_INV_SBOX_COMB_EN for a purely combinational lookup
// (o_inv_wrd_sbox follows the input every cycle, o_valid = i_en).

module aes_inv_sbox (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [31:0] i_inv_wrd_sbox,
    output logic [31:0] o_inv_wrd_sbox,
    output logic        o_valid
);

    // FIPS-197 inverse S-box, row = high nibble, column = low nibble.
    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Each lane indexes the table independently; no cross-lane terms.
    function automatic logic [31:0] inv_sbox_word(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8] = INV_SBOX[w[8*k +: 8]];
        end
        return r;
    endfunction

    logic [31:0] lut_word;
    assign lut_word = inv_sbox_word(i_inv_wrd_sbox);

`ifdef AES_INV_SBOX_COMB_EN
    // Clock and reset stay on the port list so both builds drop into the same socket.
    logic unused_clk_rst;
    assign unused_clk_rst = i_clk ^ i_rst;

    assign o_inv_wrd_sbox = lut_word;
    assign o_valid        = i_en;
`else
    logic [31:0] word_q;
    logic        valid_q;

    // Word register only loads on i_en, so an unknown input while idle cannot
    // reach the held result.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= i_en;
            if (i_en) begin
                word_q <= lut_word;
            end
        end
    end

    assign o_inv_wrd_sbox = word_q;
    assign o_valid        = valid_q;
`endif

endmodule

// File: tb/tb_aes_inv_sbox.sv
module tb_aes_inv_sbox;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_en;
    logic [31:0] i_inv_wrd_sbox;
    logic [31:0] o_inv_wrd_sbox;
    logic        o_valid;

    always #5 i_clk = ~i_clk;

    aes_inv_sbox dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_en           (i_en),
        .i_inv_wrd_sbox (i_inv_wrd_sbox),
        .o_inv_wrd_sbox (o_inv_wrd_sbox),
        .o_valid        (o_valid)
    );

    // Forward S-box; the inverse reference is derived from it at start-up.
    localparam logic [7:0] FWD [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef struct {
        logic [31:0] din;
        logic [31:0] exp_word;
        logic        exp_vld;
        logic [31:0] want;
        bit          chk_want;
    } sb_t;

    logic [7:0]  inv_model [0:255];
    logic [31:0] last_word;
    sb_t         sb_q [$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    function automatic logic [31:0] inv_word(input logic [31:0] w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = inv_model[w[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [31:0] fwd_word(input logic [31:0] w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = FWD[w[8*k +: 8]];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one word at the falling edge, queue its expectation, then pop and
    // compare once the DUT should present it.
    task automatic step(input logic en, input logic [31:0] din,
                        input logic [31:0] want, input bit chk_want);
        sb_t e;
        @(negedge i_clk);
        i_en           = en;
        i_inv_wrd_sbox = din;
        e.din      = din;
        e.exp_vld  = en;
        e.want     = want;
        e.chk_want = chk_want;
`ifdef AES_INV_SBOX_COMB_EN
        e.exp_word = (en === 1'b1 || !$isunknown(din)) ? inv_word(din) : 32'h0;
`else
        e.exp_word = en ? inv_word(din) : last_word;
        if (en) last_word = e.exp_word;
`endif
        sb_q.push_back(e);
`ifdef AES_INV_SBOX_COMB_EN
        #1;
`else
        @(posedge i_clk);
        #1;
`endif
        e = sb_q.pop_front();
        chk($sformatf("word din=%h", e.din), o_inv_wrd_sbox, e.exp_word);
        chk($sformatf("valid din=%h", e.din), {31'h0, o_valid}, {31'h0, e.exp_vld});
        if (e.chk_want) chk($sformatf("directed din=%h", e.din), o_inv_wrd_sbox, e.want);
        if (e.exp_vld) chk($sformatf("roundtrip din=%h", e.din), fwd_word(o_inv_wrd_sbox), e.din);
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 256; i++) inv_model[FWD[i]] = 8'(i);
        last_word      = 32'h0;
        i_rst          = 1'b1;
        i_en           = 1'b1;
        i_inv_wrd_sbox = 32'h00010203;

`ifndef AES_INV_SBOX_COMB_EN
        // Reset held with i_en active: outputs stay cleared.
        #1;
        chk("reset word t0", o_inv_wrd_sbox, 32'h0);
        chk("reset valid t0", {31'h0, o_valid}, 32'h0);
        repeat (3) begin
            @(negedge i_clk);
            chk("reset word", o_inv_wrd_sbox, 32'h0);
            chk("reset valid", {31'h0, o_valid}, 32'h0);
        end
`endif
        @(negedge i_clk);
        i_rst = 1'b0;
        i_en  = 1'b0;

        step(1'b1, 32'h00010203, 32'h52096AD5, 1'b1);
        step(1'b1, 32'h637C16FF, 32'h0001FF7D, 1'b1);
        step(1'b1, 32'hEDEDEDED, 32'h53535353, 1'b1);
        step(1'b1, 32'h63636363, 32'h00000000, 1'b1);
        step(1'b1, 32'h00010203, 32'h52096AD5, 1'b1);
        step(1'b0, $urandom, 32'h0, 1'b0);
`ifndef AES_INV_SBOX_COMB_EN
        step(1'b0, 32'hxxxxxxxx, 32'h52096AD5, 1'b1);

        // Async reset while a valid result is on the output.
        step(1'b1, 32'hEDEDEDED, 32'h53535353, 1'b1);
        #1;
        i_rst          = 1'b1;
        i_en           = 1'b1;
        i_inv_wrd_sbox = 32'hFFFFFFFF;
        #1;
        chk("async reset word", o_inv_wrd_sbox, 32'h0);
        chk("async reset valid", {31'h0, o_valid}, 32'h0);
        @(posedge i_clk);
        #1;
        chk("reset over edge word", o_inv_wrd_sbox, 32'h0);
        chk("reset over edge valid", {31'h0, o_valid}, 32'h0);
        last_word = 32'h0;
        @(negedge i_clk);
        i_rst = 1'b0;
        i_en  = 1'b0;
        step(1'b0, $urandom, 32'h0, 1'b1);
        step(1'b1, 32'hFF16ED7C, 32'h7DFF5301, 1'b1);
`endif

        // Every byte value through every lane, back-to-back.
        for (int v = 0; v < 256; v++) begin
            for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(v + 64 * k);
            step(1'b1, w, 32'h0, 1'b0);
        end
        step(1'b0, 32'h12345678, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
